// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared types and constants for the multicycle RV32I control unit.
//   state_t      : control FSM states
//   OP_*         : opcodes recognised by the decode step
//   ALU_*        : 5-bit ALUControl codes; the ALU bench uses the same set
//   result_src_t : ResultSrc mux selects
//   alu_src_a_t  : ALUSrcA mux selects
//   alu_src_b_t  : ALUSrcB mux selects
//   imm_src_t    : immediate format selects
//   aluop_t      : operation class passed to alu_decoder
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // [1:0] class, [2] OR/AND, [3] subtract, [4] shift right
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01010;
    localparam logic [4:0] ALU_SLT = 5'b01001;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_OR  = 5'b00111;
    localparam logic [4:0] ALU_SLL = 5'b00000;
    localparam logic [4:0] ALU_SRL = 5'b10000;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Combinational translation from operation class and instruction function
// fields to the ALU control code.
//   aluop         in  2  fixed ADD, fixed SUB, or decode from funct fields
//   funct3        in  3  instruction funct3
//   funct7_5      in  1  instruction bit 30
//   is_r          in  1  register-register form (bit 30 selects SUB)
//   alu_control   out 5  ALUControl code
//   funct_illegal out 1  funct combination not supported
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_r,
    output logic [4:0] alu_control,
    output logic       funct_illegal
);

    // Bit 30 is only an opcode modifier for R-type (SUB) and for shifts
    // (arithmetic right shift, unsupported). For other I-type ops it is
    // just an immediate bit and must be ignored.
    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        unique case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct3)
                    3'b000: alu_control = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010: begin
                        alu_control   = ALU_SLT;
                        funct_illegal = is_r && funct7_5;
                    end
                    3'b111: begin
                        alu_control   = ALU_AND;
                        funct_illegal = is_r && funct7_5;
                    end
                    3'b110: begin
                        alu_control   = ALU_OR;
                        funct_illegal = is_r && funct7_5;
                    end
                    3'b001: begin
                        alu_control   = ALU_SLL;
                        funct_illegal = funct7_5;
                    end
                    3'b101: begin
                        alu_control   = ALU_SRL;
                        funct_illegal = funct7_5;
                    end
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control FSM for the multicycle RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback, stalls on the memory req/ready handshake,
// resolves branches from the ALU flags and traps on unsupported encodings.
//   clk, reset_n         clock (rising edge), async active-low reset
//   Instr                instruction register contents
//   Zero, Negative       ALU flags used by branches
//   MemReady             memory completes the current access
//   TrapClr              leaves TRAP when RESET_TRAP_CLR = 0
//   MemReq, MemWrite     memory request and store strobe
//   AdrSrc               memory address select (PC / ALUOut)
//   IRWrite, PCWrite     instruction register / PC enables
//   RegWrite             register file write enable
//   ResultSrc            result mux select
//   ALUSrcA, ALUSrcB     ALU operand selects
//   ImmSrc               immediate format
//   ALUControl           ALU operation code
//   Illegal              high while trapped
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit RESET_TRAP_CLR = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Negative,
    input  logic        MemReady,
    input  logic        TrapClr,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [4:0]  ALUControl,
    output logic        Illegal
);

    state_t     state;
    state_t     next_state;
    aluop_t     aluop;
    logic       is_r;
    logic       funct_illegal;
    logic [4:0] alu_control;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = Instr[6:0];
    assign funct3            = Instr[14:12];
    assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // The ALU class depends only on state, which keeps the decoder off the
    // combinational path that consumes its illegal flag.
    always_comb begin
        aluop = ALUOP_ADD;
        unique case (state)
            S_EXECR, S_EXECI: aluop = ALUOP_FUNCT;
            S_BRANCH:         aluop = ALUOP_SUB;
            default:          aluop = ALUOP_ADD;
        endcase
    end

    assign is_r = (state == S_EXECR);

    alu_decoder u_alu_decoder (
        .aluop         (aluop),
        .funct3        (funct3),
        .funct7_5      (Instr[30]),
        .is_r          (is_r),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    assign ALUControl = alu_control;

    always_comb begin
        next_state = state;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ImmSrc     = IMM_I;
        Illegal    = 1'b0;

        unique case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target is precomputed into ALUOut here; JAL needs
                // the J-format immediate for its target to be correct.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                unique case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_LOAD) begin
                    ImmSrc     = IMM_I;
                    next_state = S_MEMREAD;
                end else begin
                    ImmSrc     = IMM_S;
                    next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) next_state = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                next_state = funct_illegal ? S_TRAP : S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                next_state = funct_illegal ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                // blt uses the raw sign of rs1-rs2; overflow is deliberately ignored.
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ResultSrc  = RES_ALUOUT;
                next_state = S_FETCH;
                unique case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = !Zero;
                    3'b100:  PCWrite = Negative;
                    default: next_state = S_TRAP;
                endcase
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                next_state = S_ALUWB;
            end
            S_TRAP: begin
                Illegal = 1'b1;
                if (!RESET_TRAP_CLR && TrapClr) next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // While reset is held the state already reads FETCH, but nothing may be
        // requested or written until reset is released.
        if (!reset_n) begin
            next_state = S_FETCH;
            MemReq     = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = RES_ALUOUT;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_RD2;
            ImmSrc     = IMM_I;
            Illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. A per-instruction model expands
// each instruction into the expected per-cycle outputs and the inputs to
// apply on that cycle; the bench steps the DUT in lockstep with that plan.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Instr;
    logic        Zero;
    logic        Negative;
    logic        MemReady;
    logic        TrapClr;
    logic        MemReq;
    logic        MemWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [4:0]  ALUControl;
    logic        Illegal;

    multicycle_ctrl #(.RESET_TRAP_CLR(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Instr      (Instr),
        .Zero       (Zero),
        .Negative   (Negative),
        .MemReady   (MemReady),
        .TrapClr    (TrapClr),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] E_ADD = 5'b00010;
    localparam logic [4:0] E_SUB = 5'b01010;
    localparam logic [4:0] E_SLT = 5'b01001;
    localparam logic [4:0] E_AND = 5'b00011;
    localparam logic [4:0] E_OR  = 5'b00111;
    localparam logic [4:0] E_SLL = 5'b00000;
    localparam logic [4:0] E_SRL = 5'b10000;

    typedef struct {
        string      phase;
        bit         instr_valid;
        bit         ready;
        bit         zero;
        bit         neg;
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        bit         adr_c;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] res;
        bit         res_c;
        logic [1:0] a;
        bit         a_c;
        logic [1:0] b;
        bit         b_c;
        logic [1:0] imm;
        bit         imm_c;
        logic [4:0] alu;
        bit         alu_c;
    } cyc_t;

    cyc_t        plan_q[$];
    logic [31:0] cur_ins;
    logic [31:0] rnd_ins;
    int          checks   = 0;
    int          errors   = 0;
    int          cycle_no = 0;

    function automatic cyc_t blank(input string phase);
        cyc_t c;
        c.phase       = phase;
        c.instr_valid = 1'b1;
        c.ready       = 1'($urandom);
        c.zero        = 1'($urandom);
        c.neg         = 1'($urandom);
        c.mem_req     = 1'b0;
        c.mem_write   = 1'b0;
        c.adr_src     = 1'b0;
        c.adr_c       = 1'b0;
        c.ir_write    = 1'b0;
        c.pc_write    = 1'b0;
        c.reg_write   = 1'b0;
        c.illegal     = 1'b0;
        c.res         = 2'b00;
        c.res_c       = 1'b0;
        c.a           = 2'b00;
        c.a_c         = 1'b0;
        c.b           = 2'b00;
        c.b_c         = 1'b0;
        c.imm         = 2'b00;
        c.imm_c       = 1'b0;
        c.alu         = E_ADD;
        c.alu_c       = 1'b0;
        return c;
    endfunction

    // Supported ALU functions: 000 add/sub, 010 slt, 111 and, 110 or,
    // 001 sll, 101 srl. Bit 30 means sub for R-type 000, is unsupported for
    // other R-type functions and for shifts, and is an immediate bit otherwise.
    function automatic void expectAlu(input logic [2:0] f3, input bit f7, input bit is_r,
                                      output logic [4:0] alu, output bit legal);
        legal = 1'b1;
        alu   = E_ADD;
        case (f3)
            3'b000: alu = (is_r && f7) ? E_SUB : E_ADD;
            3'b010: begin alu = E_SLT; legal = !(is_r && f7); end
            3'b111: begin alu = E_AND; legal = !(is_r && f7); end
            3'b110: begin alu = E_OR;  legal = !(is_r && f7); end
            3'b001: begin alu = E_SLL; legal = !f7; end
            3'b101: begin alu = E_SRL; legal = !f7; end
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic void planTrap(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank("TRAP");
            c.instr_valid = 1'b0;
            c.illegal     = 1'b1;
            plan_q.push_back(c);
        end
    endfunction

    function automatic void planWriteback();
        cyc_t c;
        c = blank("ALUWB");
        c.res = 2'b00; c.res_c = 1'b1;
        c.reg_write = 1'b1;
        plan_q.push_back(c);
    endfunction

    // Expands one instruction into cycles. fw/mw are the number of cycles
    // memory holds MemReady low for the fetch and the data access.
    function automatic void planInstr(input logic [31:0] ins, input bit zero, input bit neg,
                                      input int fw, input int mw);
        logic [6:0] op;
        logic [2:0] f3;
        bit         f7;
        bit         is_r;
        bit         legal;
        logic [4:0] alu;
        cyc_t       c;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[30];
        legal = 1'b1;
        for (int i = 0; i <= fw; i++) begin
            c = blank("FETCH");
            c.instr_valid = 1'b0;
            c.ready    = (i == fw);
            c.mem_req  = 1'b1;
            c.adr_c    = 1'b1;
            c.ir_write = c.ready;
            c.pc_write = c.ready;
            c.res = 2'b10; c.res_c = 1'b1;
            c.a   = 2'b00; c.a_c   = 1'b1;
            c.b   = 2'b10; c.b_c   = 1'b1;
            c.alu = E_ADD; c.alu_c = 1'b1;
            plan_q.push_back(c);
        end
        c = blank("DECODE");
        c.a   = 2'b01; c.a_c   = 1'b1;
        c.b   = 2'b01; c.b_c   = 1'b1;
        c.imm = 2'b10; c.imm_c = (op != 7'b1101111);
        c.alu = E_ADD; c.alu_c = 1'b1;
        plan_q.push_back(c);
        case (op)
            7'b0000011, 7'b0100011: begin
                c = blank("MEMADR");
                c.a   = 2'b10; c.a_c = 1'b1;
                c.b   = 2'b01; c.b_c = 1'b1;
                c.imm = (op == 7'b0000011) ? 2'b00 : 2'b01; c.imm_c = 1'b1;
                c.alu = E_ADD; c.alu_c = 1'b1;
                plan_q.push_back(c);
                for (int i = 0; i <= mw; i++) begin
                    c = blank((op == 7'b0000011) ? "MEMREAD" : "MEMWRITE");
                    c.ready     = (i == mw);
                    c.mem_req   = 1'b1;
                    c.mem_write = (op == 7'b0100011);
                    c.adr_src   = 1'b1;
                    c.adr_c     = 1'b1;
                    plan_q.push_back(c);
                end
                if (op == 7'b0000011) begin
                    c = blank("MEMWB");
                    c.res = 2'b01; c.res_c = 1'b1;
                    c.reg_write = 1'b1;
                    plan_q.push_back(c);
                end
            end
            7'b0110011, 7'b0010011: begin
                is_r = (op == 7'b0110011);
                expectAlu(f3, f7, is_r, alu, legal);
                c = blank(is_r ? "EXECR" : "EXECI");
                c.a = 2'b10; c.a_c = 1'b1;
                c.b = is_r ? 2'b00 : 2'b01; c.b_c = 1'b1;
                c.imm = 2'b00; c.imm_c = !is_r;
                c.alu = alu; c.alu_c = legal;
                plan_q.push_back(c);
                if (legal) planWriteback();
                else       planTrap(4);
            end
            7'b1100011: begin
                c = blank("BRANCH");
                c.zero = zero;
                c.neg  = neg;
                c.a   = 2'b10; c.a_c   = 1'b1;
                c.b   = 2'b00; c.b_c   = 1'b1;
                c.res = 2'b00; c.res_c = 1'b1;
                c.alu = E_SUB; c.alu_c = 1'b1;
                case (f3)
                    3'b000:  c.pc_write = zero;
                    3'b001:  c.pc_write = !zero;
                    3'b100:  c.pc_write = neg;
                    default: legal = 1'b0;
                endcase
                plan_q.push_back(c);
                if (!legal) planTrap(4);
            end
            7'b1101111: begin
                c = blank("JAL");
                c.a   = 2'b01; c.a_c   = 1'b1;
                c.b   = 2'b10; c.b_c   = 1'b1;
                c.res = 2'b00; c.res_c = 1'b1;
                c.alu = E_ADD; c.alu_c = 1'b1;
                c.pc_write = 1'b1;
                plan_q.push_back(c);
                planWriteback();
            end
            default: planTrap(4);
        endcase
    endfunction

    task automatic checkOutput(input cyc_t c);
        logic [19:0] obs;
        logic [19:0] exp_v;
        logic [19:0] care;
        obs   = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
        exp_v = {c.mem_req, c.mem_write, c.adr_src, c.ir_write, c.pc_write, c.reg_write,
                 c.illegal, c.res, c.a, c.b, c.imm, c.alu};
        care  = {2'b11, c.adr_c, 4'b1111, {2{c.res_c}}, {2{c.a_c}}, {2{c.b_c}},
                 {2{c.imm_c}}, {5{c.alu_c}}};
        checks++;
        assert ((obs & care) === (exp_v & care)) else begin
            errors++;
            $error("[TB] FAIL %s (cycle %0d instr %08h) observed %05h expected %05h care %05h",
                   c.phase, cycle_no, cur_ins, obs, exp_v, care);
        end
    endtask

    // Called at a falling edge: drive the cycle's inputs, check, then move
    // to the next falling edge (one rising edge in between).
    task automatic applyStimulus(input cyc_t c);
        Instr    = c.instr_valid ? cur_ins : $urandom;
        Zero     = c.zero;
        Negative = c.neg;
        MemReady = c.ready;
        TrapClr  = 1'($urandom);
        #1;
        checkOutput(c);
        cycle_no++;
        @(negedge clk);
    endtask

    task automatic runPlan(input int max_cycles);
        int n;
        n = 0;
        while (plan_q.size() > 0 && (max_cycles < 0 || n < max_cycles)) begin
            applyStimulus(plan_q.pop_front());
            n++;
        end
        plan_q.delete();
    endtask

    task automatic runInstr(input logic [31:0] ins, input bit zero, input bit neg,
                            input int fw, input int mw);
        cur_ins = ins;
        planInstr(ins, zero, neg, fw, mw);
        runPlan(-1);
    endtask

    task automatic checkReset(input string tag);
        cyc_t c;
        c = blank(tag);
        c.adr_c = 1'b1;
        c.res_c = 1'b1;
        c.a_c   = 1'b1;
        c.b_c   = 1'b1;
        c.imm_c = 1'b1;
        c.alu   = E_ADD;
        c.alu_c = 1'b1;
        checkOutput(c);
    endtask

    // Asserts reset asynchronously with MemReady high, checks that everything
    // is quiet across a rising edge, and releases at the next falling edge.
    task automatic doReset(input string tag);
        reset_n  = 1'b0;
        MemReady = 1'b1;
        TrapClr  = 1'b1;
        Instr    = $urandom;
        #1;
        checkReset(tag);
        @(posedge clk);
        #1;
        checkReset(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [2:0] pickAluF3();
        case ($urandom_range(0, 5))
            0:       return 3'b000;
            1:       return 3'b010;
            2:       return 3'b111;
            3:       return 3'b110;
            4:       return 3'b001;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [31:0] randInstr();
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        f3  = pickAluF3();
        case ($urandom_range(0, 5))
            0: begin
                f7 = (f3 == 3'b000 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            1: begin
                if (f3 == 3'b001 || f3 == 3'b101) imm[11:5] = 7'h00;
                return {imm, rs1, f3, rd, 7'b0010011};
            end
            2: return {imm, rs1, 3'b010, rd, 7'b0000011};
            3: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            4: begin
                case ($urandom_range(0, 2))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    default: f3 = 3'b100;
                endcase
                return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b1100011};
            end
            default: return {20'($urandom), rd, 7'b1101111};
        endcase
    endfunction

    initial begin
        reset_n  = 1'b0;
        Instr    = 32'h0;
        Zero     = 1'b0;
        Negative = 1'b0;
        MemReady = 1'b0;
        TrapClr  = 1'b0;
        cur_ins  = 32'h0;

        doReset("RESET start");

        // add x3,x1,x2 with memory always ready: FETCH, DECODE, EXECR, ALUWB
        runInstr(32'h002081B3, 1'b0, 1'b0, 0, 0);
        runInstr(32'h402081B3, 1'b0, 1'b0, 0, 0);   // sub
        runInstr(32'h0020A1B3, 1'b0, 1'b0, 0, 0);   // slt
        runInstr(32'h0020D1B3, 1'b0, 1'b0, 0, 0);   // srl
        runInstr(32'h0050E193, 1'b0, 1'b0, 0, 0);   // ori
        runInstr(32'h0020F1B3, 1'b0, 1'b0, 0, 0);   // and
        runInstr(32'h00209193, 1'b0, 1'b0, 0, 0);   // slli

        // lw x5,8(x1) with MemReady low for 3 cycles in MEMREAD
        runInstr({12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011}, 1'b0, 1'b0, 1, 3);
        // sw x2,4(x1) with stalls on both fetch and store
        runInstr({7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 1'b0, 1'b0, 2, 2);

        // beq / bne / blt against the flags
        runInstr({7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011}, 1'b1, 1'b0, 0, 0);
        runInstr({7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011}, 1'b0, 1'b1, 0, 0);
        runInstr({7'd0, 5'd2, 5'd1, 3'b100, 5'd8, 7'b1100011}, 1'b0, 1'b1, 0, 0);
        runInstr({7'd0, 5'd2, 5'd1, 3'b100, 5'd8, 7'b1100011}, 1'b1, 1'b0, 0, 0);
        runInstr({7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011}, 1'b1, 1'b0, 0, 0);
        runInstr({7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011}, 1'b0, 1'b0, 0, 0);

        // jal x1, +16
        runInstr({20'h01000, 5'd1, 7'b1101111}, 1'b0, 1'b0, 1, 0);

        // Reset while a load waits in MEMREAD
        cur_ins = {12'd12, 5'd2, 3'b010, 5'd6, 7'b0000011};
        planInstr(cur_ins, 1'b0, 1'b0, 0, 5);
        runPlan(4);
        doReset("RESET mid MEMREAD");
        runInstr(32'h002081B3, 1'b0, 1'b0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            rnd_ins = randInstr();
            runInstr(rnd_ins, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // R-type funct3=011 traps and stays trapped despite TrapClr
        runInstr({7'h00, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011}, 1'b0, 1'b0, 0, 0);
        doReset("RESET after funct trap");
        runInstr(32'h002081B3, 1'b0, 1'b0, 0, 0);

        // Unknown opcode 0x7F
        runInstr(32'h0000007F, 1'b0, 1'b0, 0, 0);
        doReset("RESET after opcode trap");
        runInstr(32'h0050E193, 1'b0, 1'b0, 0, 0);

        // Branch with unsupported funct3 also traps
        runInstr({7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b1100011}, 1'b1, 1'b1, 0, 0);
        doReset("RESET after branch trap");
        runInstr(32'h402081B3, 1'b0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
